// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR access path: Zicsr funct3
// encodings, the implemented CSR addresses and the access FSM state type.
package csr_pkg;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MISA       = 12'h301;
  localparam logic [11:0] CSR_MIE        = 12'h304;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MIP        = 12'h344;
  localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
  localparam logic [11:0] CSR_MARCHID    = 12'hF12;
  localparam logic [11:0] CSR_MIMPID     = 12'hF13;
  localparam logic [11:0] CSR_MHARTID    = 12'hF14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

endpackage

// File: rtl/csr_addr_decode.sv
// Combinational CSR address decoder: reports whether an address is
// implemented and whether it lives in the read-only space (addr[11:10]==11).
module csr_addr_decode
  import csr_pkg::*;
#(
  parameter int CSR_ADDR_W = 12
) (
  input  logic [CSR_ADDR_W-1:0] csr_addr_i,
  output logic                  mapped_o,
  output logic                  read_only_o
);

  // Match the address against the implemented CSR set.
  always_comb begin
    mapped_o = 1'b0;
    case (csr_addr_i)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MCOUNTEREN,
      CSR_MEPC, CSR_MCAUSE, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
      CSR_MCYCLEH, CSR_MINSTRETH, CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID, CSR_MHARTID: mapped_o = 1'b1;
      default:                 mapped_o = 1'b0;
    endcase
  end

  assign read_only_o = (csr_addr_i[11:10] == 2'b11);

endmodule

// File: rtl/csr_access_unit.sv
// Initiator for the CSR register-file bus: takes one Zicsr instruction,
// performs the read / modify / write sequence and returns the old value.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            funct3_i,
  input  logic [CSR_ADDR_W-1:0] csr_addr_i,
  input  logic [4:0]            rs1_idx_i,
  input  logic [4:0]            rd_idx_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [XLEN-1:0]       resp_rd_data_o,
  output logic [4:0]            resp_rd_idx_o,
  output logic                  resp_illegal_o,
  output logic [31:0]           csr_address_o,
  output logic                  csr_en_read_o,
  output logic                  csr_en_write_o,
  output logic [XLEN-1:0]       csr_data_o,
  input  logic [XLEN-1:0]       csr_data_i
);

  state_t                r_state, w_next;
  logic [CSR_ADDR_W-1:0] r_addr;
  logic [1:0]            r_op;
  logic [XLEN-1:0]       r_src, r_old, r_wdata;
  logic [4:0]            r_rd_idx;
  logic                  r_illegal, r_wr_supp;

  logic                  w_mapped, w_read_only, w_accept;
  logic                  w_rd_supp, w_wr_supp, w_illegal;
  logic [XLEN-1:0]       w_src, w_new;

  csr_addr_decode #(.CSR_ADDR_W(CSR_ADDR_W)) u_decode (
    .csr_addr_i  (csr_addr_i),
    .mapped_o    (w_mapped),
    .read_only_o (w_read_only)
  );

  // Read-modify-write combine: RW replaces, RS sets bits, RC clears bits.
  function automatic logic [XLEN-1:0] rmw(input logic [1:0] op,
                                          input logic [XLEN-1:0] old,
                                          input logic [XLEN-1:0] src);
    case (op)
      2'b01:   rmw = src;
      2'b10:   rmw = old | src;
      2'b11:   rmw = old & ~src;
      default: rmw = old;
    endcase
  endfunction

  assign w_accept  = req_valid_i && (r_state == S_IDLE);
  assign w_src     = funct3_i[2] ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_data_i;
  // RW variants always write; set/clear variants with x0/zimm=0 never write.
  assign w_rd_supp = (funct3_i[1:0] == 2'b01) && (rd_idx_i == 5'd0);
  assign w_wr_supp = (funct3_i[1:0] != 2'b01) && (rs1_idx_i == 5'd0);
  assign w_illegal = (funct3_i[1:0] == 2'b00) || !w_mapped ||
                     (w_read_only && !w_wr_supp);
  assign w_new     = rmw(r_op, csr_data_i, r_src);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic for the access sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_illegal)      w_next = S_RESP;
        else if (w_rd_supp) w_next = S_WR;
        else                w_next = S_RD;
      end
      S_RD:   w_next = S_CAP;
      S_CAP:  w_next = r_wr_supp ? S_RESP : S_WR;
      S_WR:   w_next = S_RESP;
      S_RESP: if (resp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch at accept, old-value capture and new-value compute in CAP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr    <= '0;
      r_op      <= '0;
      r_src     <= '0;
      r_old     <= '0;
      r_wdata   <= '0;
      r_rd_idx  <= '0;
      r_illegal <= 1'b0;
      r_wr_supp <= 1'b0;
    end else if (w_accept) begin
      r_addr    <= csr_addr_i;
      r_op      <= funct3_i[1:0];
      r_src     <= w_src;
      r_old     <= '0;
      r_rd_idx  <= rd_idx_i;
      r_illegal <= w_illegal;
      r_wr_supp <= w_wr_supp;
      if (!w_illegal && w_rd_supp) r_wdata <= w_src;
    end else if (r_state == S_CAP) begin
      r_old   <= csr_data_i;
      r_wdata <= w_new;
    end
  end

  assign req_ready_o    = (r_state == S_IDLE);
  assign resp_valid_o   = (r_state == S_RESP);
  assign resp_rd_data_o = r_old;
  assign resp_rd_idx_o  = r_rd_idx;
  assign resp_illegal_o = r_illegal;
  assign csr_address_o  = {{(32-CSR_ADDR_W){1'b0}}, r_addr};
  assign csr_en_read_o  = (r_state == S_RD);
  assign csr_en_write_o = (r_state == S_WR);
  assign csr_data_o     = r_wdata;

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Initiator side of the machine-mode CSR register-file bus. Accepts one decoded Zicsr instruction at a time from the execute stage: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI or CSRRCI. Runs the read / modify / write sequence against the CSR register file over its address/en_read/en_write/data port. Returns the old CSR value for rd, or flags the access as illegal.

## Interface

Parameters:
- XLEN, 32, data width of CSR bus and rs1 operand.
- CSR_ADDR_W, 12, CSR address width; zero-extended to 32 bits on the bus.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- req_valid_i  in  1  instruction request valid.
- req_ready_o  out  1  unit can accept a request; high only in IDLE.
- funct3_i  in  3  Zicsr funct3.
- csr_addr_i  in  12  target CSR address.
- rs1_idx_i  in  5  rs1 index; also the zimm for the I variants.
- rd_idx_i  in  5  destination index.
- rs1_data_i  in  XLEN  rs1 register value.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  consumer accepts the response.
- resp_rd_data_o  out  XLEN  old CSR value; 0 when read was suppressed or access was illegal.
- resp_rd_idx_o  out  5  echoed rd_idx_i.
- resp_illegal_o  out  1  illegal-instruction flag.
- csr_address_o  out  32  CSR file address, {20'b0, addr}.
- csr_en_read_o  out  1  CSR file read enable.
- csr_en_write_o  out  1  CSR file write enable.
- csr_data_o  out  XLEN  CSR file write data.
- csr_data_i  in  XLEN  CSR file read data; registered, valid the cycle after csr_en_read_o.

## Operation

- Mapped CSRs: 0x301, 0xF11–0xF14, 0x342, 0x300, 0x305, 0x341, 0x344, 0x304, 0xB00, 0xB80, 0xB02, 0xB82, 0x306.
- Read-only CSRs: addresses with addr[11:10]==2'b11.
- Illegal access, any of:
  - funct3 is 000 or 100.
  - Address is unmapped.
  - A write would occur to a read-only CSR.
- Illegal access behaviour: no bus activity; response has resp_illegal_o=1 and rd_data=0.
- Operand: src = rs1_data_i when funct3[2]=0; src = {27'b0, rs1_idx_i} when funct3[2]=1.
- New value, from funct3[1:0]:
  - 01 (RW): new = src.
  - 10 (RS): new = old | src.
  - 11 (RC): new = old & ~src.
- Read suppressed: RW/RWI with rd_idx_i==0.
- Write suppressed: RS/RC/RSI/RCI with rs1_idx_i==0; the read-only check then does not trigger.
- Bus rules:
  - csr_en_read_o and csr_en_write_o are never high in the same cycle.
  - Both are zero outside RD/WR.
  - csr_address_o holds the latched address from accept until IDLE.
- FSM states: IDLE, RD, CAP, WR, RESP.
  - IDLE→RESP: accept (req_valid_i & req_ready_o) and illegal.
  - IDLE→WR: accept and read suppressed.
  - IDLE→RD: otherwise on accept.
  - RD→CAP: always; old value latched from csr_data_i in CAP.
  - CAP→WR: write needed; new value registered into csr_data_o.
  - CAP→RESP: write suppressed.
  - WR→RESP: always.
  - RESP→IDLE: on resp_ready_i.
- Request fields are latched at accept; input changes afterwards are ignored.

## Timing

- Accept in cycle 0; cycles below count from there.
- Full read+write:
  - RD in cycle 1, en_read high.
  - CAP in cycle 2.
  - WR in cycle 3, en_write high, csr_data_o = new.
  - resp_valid_o high from cycle 4.
- Read only (write suppressed): resp_valid_o from cycle 3.
- Write only (read suppressed): WR in cycle 1, resp_valid_o from cycle 2.
- Illegal: resp_valid_o from cycle 1.
- resp_valid_o and all resp_* are held stable until resp_ready_i is sampled high. Next req_ready_o comes the cycle after.
- Back-to-back issue: minimum 2 cycles per instruction (illegal case with resp_ready_i tied high).
- Reset values: every output 0, except req_ready_o, which is 1 after the first post-reset edge (state IDLE).
- rst_i mid-sequence:
  - Returns to IDLE next edge and drops any pending write and response.
  - The CSR file shares rst_i and clears itself.

## Structure

- Shared package csr_pkg holds:
  - funct3 constants CSRRW..CSRRCI.
  - The 16 CSR address localparams.
  - The FSM state typedef.
- Sub-module csr_addr_decode: combinational; csr_addr → {mapped, read_only}.
  - Shared later by the trap controller.
- Top holds the FSM, operand mux, RMW datapath and response registers.

## Test plan

- CSRRW x5, 0x305 with rs1=0x8000_0100 and CSR holding 0x0: en_read in cycle 1, en_write with 0x8000_0100 in cycle 3, resp rd_data=0x0, rd_idx=5 in cycle 4.
- CSRRS rd=3, rs1=x0 on 0xF11 holding 0x0000_0489: no en_write, no illegal, rd_data=0x489 in cycle 3.
- CSRRCI 0x300 zimm=0x08 with mstatus 0x0000_1888: write data 0x0000_1880.
- CSRRW 0xF12 (write to read-only) and CSRRS 0x7C0 (unmapped): resp_illegal_o=1 in cycle 1, rd_data=0, bus enables never asserted.
- resp_ready_i held low 3 cycles in RESP: resp_* stable, req_ready_o low; deassert then reassert resp_ready_i → IDLE.
- rst_i pulsed in WR state: csr_en_write_o=0 next cycle, resp_valid_o never asserted, req_ready_o=1 after reset.
